// File: rtl/ysyx_22040237_mc_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: widths, reset PC and state encodings.
// The optional perf counters are enabled with YSYX_22040237_PERF_CNT_EN (see top).
package ysyx_22040237_mc_seq_pkg;

  localparam int          ysyx_22040237_REG_WIDTH  = 64;
  localparam int          ysyx_22040237_INST_WIDTH = 32;
  localparam logic [63:0] ysyx_22040237_RESET_PC   = 64'h8000_0000;

  typedef enum logic [2:0] {
    ST_IF    = 3'd0,
    ST_ID    = 3'd1,
    ST_EX    = 3'd2,
    ST_LS    = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_IF) || (s == ST_LS);
  endfunction

endpackage

// File: rtl/ysyx_22040237_mem_wait_timer.sv
// Wait-cycle counter shared by IF and LS; expire_o marks the last cycle an ack may still arrive.
module ysyx_22040237_mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A miss on this cycle would be the TIMEOUT-th non-ack cycle.
  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ysyx_22040237_mc_seq.sv
// Multi-cycle core sequencer: owns the PC and steps IF->ID->EX->LS->WB with memory req/ack handshakes.
// Define YSYX_22040237_PERF_CNT_EN to add cycle_cnt_o / instret_o performance counters.
module ysyx_22040237_mc_seq
  import ysyx_22040237_mc_seq_pkg::*;
#(
  parameter int               XLEN        = ysyx_22040237_REG_WIDTH,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(ysyx_22040237_RESET_PC),
  parameter int               MEM_TIMEOUT = 16,
  parameter int               CNT_W       = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  input  logic            imem_err_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     inst_o,
  output logic            inst_vld_o,
  input  logic            is_mem_i,
  input  logic            halt_i,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            dmem_req_o,
  input  logic            dmem_ack_i,
  input  logic            rd_wr_en_i,
  output logic            rf_wr_en_o,
  output logic [2:0]      state_o,
  output logic            halted_o,
`ifdef YSYX_22040237_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o,
`endif
  output logic            fault_o
);

  // Handshakes: a req is held high for the whole IF/LS stay; the matching ack is a single-cycle
  // completion that is only looked at while that req is high.

  state_e                       state_q, state_d;
  logic [XLEN-1:0]              pc_q, pc_d, next_pc_q, next_pc_d;
  logic [ysyx_22040237_INST_WIDTH-1:0] inst_q, inst_d;
  logic                         in_wait, ack_now, expire;

  assign in_wait = is_wait_state(state_q);
  assign ack_now = (state_q == ST_IF) ? imem_ack_i : dmem_ack_i;

  ysyx_22040237_mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (~in_wait | ack_now),
    .inc_i    (in_wait & ~ack_now),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    inst_d     = inst_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    inst_vld_o = 1'b0;
    rf_wr_en_o = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          if (imem_err_i) state_d = ST_FAULT;
          else begin
            inst_d  = imem_rdata_i;
            state_d = ST_ID;
          end
        end else if (expire) state_d = ST_FAULT;
      end
      ST_ID: begin
        inst_vld_o = 1'b1;
        state_d    = ST_EX;
      end
      ST_EX: begin
        if (halt_i) state_d = ST_HALT;
        else if (jump_flag_i && (jump_addr_i[1:0] != 2'b00)) state_d = ST_FAULT;
        else begin
          next_pc_d = jump_flag_i ? jump_addr_i : pc_q + XLEN'(4);
          state_d   = is_mem_i ? ST_LS : ST_WB;
        end
      end
      ST_LS: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i)  state_d = ST_WB;
        else if (expire) state_d = ST_FAULT;
      end
      ST_WB: begin
        rf_wr_en_o = rd_wr_en_i;
        pc_d       = next_pc_q;
        state_d    = ST_IF;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IF;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      inst_q    <= inst_d;
    end
  end

  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT);
  assign fault_o  = (state_q == ST_FAULT);

`ifdef YSYX_22040237_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      if (state_q != ST_HALT && state_q != ST_FAULT) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (state_q == ST_WB)                          instret_q   <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule

// File: tb/tb_ysyx_22040237_mc_seq.sv
// Bench for ysyx_22040237_mc_seq: per-instruction schedules expand into expected per-cycle outputs.
module tb_ysyx_22040237_mc_seq;

  localparam logic [2:0]  S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_LS = 3'd3,
                          S_WB = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6;
  localparam int          TMO    = 16;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc_o;
  logic        imem_req_o, imem_ack_i = 1'b0, imem_err_i = 1'b0;
  logic [31:0] imem_rdata_i = '0, inst_o;
  logic        inst_vld_o, is_mem_i = 1'b0, halt_i = 1'b0, jump_flag_i = 1'b0;
  logic [63:0] jump_addr_i = '0;
  logic        dmem_req_o, dmem_ack_i = 1'b0, rd_wr_en_i = 1'b0, rf_wr_en_o;
  logic [2:0]  state_o;
  logic        halted_o, fault_o;
`ifdef YSYX_22040237_PERF_CNT_EN
  logic [63:0] cycle_cnt_o, instret_o;
`endif

  ysyx_22040237_mc_seq dut (
    .clk(clk), .rst(rst), .pc_o(pc_o),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .imem_err_i(imem_err_i),
    .imem_rdata_i(imem_rdata_i), .inst_o(inst_o), .inst_vld_o(inst_vld_o),
    .is_mem_i(is_mem_i), .halt_i(halt_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i), .rd_wr_en_i(rd_wr_en_i),
    .rf_wr_en_o(rf_wr_en_o), .state_o(state_o), .halted_o(halted_o),
`ifdef YSYX_22040237_PERF_CNT_EN
    .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o),
`endif
    .fault_o(fault_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    logic [2:0]  st;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        imem_req, dmem_req, vld, rf, halted, fault;
    logic [63:0] cyc, ret;
  } exp_t;

  typedef struct {
    int          iw;
    bit          ierr;
    bit          is_mem;
    int          dw;
    bit          halt;
    bit          jump;
    logic [63:0] jaddr;
    bit          rd_we;
    logic [31:0] inst;
    int          rst_ls;
  } ins_t;

  exp_t        exp_q[$];
  int          n_tests = 0, n_fail = 0;
  logic [63:0] m_pc = RST_PC, m_cyc = 0, m_ret = 0;
  logic [31:0] m_inst = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always begin
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state",    64'(state_o),    64'(e.st));
      chk("pc",       pc_o,            e.pc);
      chk("inst",     64'(inst_o),     64'(e.inst));
      chk("imem_req", 64'(imem_req_o), 64'(e.imem_req));
      chk("dmem_req", 64'(dmem_req_o), 64'(e.dmem_req));
      chk("inst_vld", 64'(inst_vld_o), 64'(e.vld));
      chk("rf_wr_en", 64'(rf_wr_en_o), 64'(e.rf));
      chk("halted",   64'(halted_o),   64'(e.halted));
      chk("fault",    64'(fault_o),    64'(e.fault));
`ifdef YSYX_22040237_PERF_CNT_EN
      chk("cycle_cnt", cycle_cnt_o, e.cyc);
      chk("instret",   instret_o,   e.ret);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic noise();
    rst          = 1'b0;
    imem_ack_i   = 1'($urandom_range(0, 1));
    imem_err_i   = 1'($urandom_range(0, 1));
    imem_rdata_i = $urandom;
    is_mem_i     = 1'($urandom_range(0, 1));
    halt_i       = 1'($urandom_range(0, 1));
    jump_flag_i  = 1'($urandom_range(0, 1));
    jump_addr_i  = {$urandom, $urandom};
    dmem_ack_i   = 1'($urandom_range(0, 1));
    rd_wr_en_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic emit(input logic [2:0] st, input logic rfw);
    exp_t e;
    e.st = st; e.pc = m_pc; e.inst = m_inst;
    e.imem_req = (st == S_IF); e.dmem_req = (st == S_LS); e.vld = (st == S_ID);
    e.rf = rfw; e.halted = (st == S_HALT); e.fault = (st == S_FAULT);
    e.cyc = m_cyc; e.ret = m_ret;
    exp_q.push_back(e);
    if (st != S_HALT && st != S_FAULT) m_cyc++;
    if (st == S_WB) m_ret++;
  endtask

  task automatic absorb(input logic [2:0] st);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); noise(); emit(st, 1'b0);
    end
  endtask

  task automatic do_reset(input int n, input bit check);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); noise(); rst = 1'b1;
      if (check && i == 1) begin
        #1;
        chk("rst_dmem_req", 64'(dmem_req_o), 64'd0);
        chk("rst_pc",       pc_o,            RST_PC);
      end
    end
    m_pc = RST_PC; m_inst = '0; m_cyc = '0; m_ret = '0;
  endtask

  // outcome: 0 retired, 1 halted, 2 faulted, 3 abandoned for a reset in LS
  task automatic run(input ins_t d, output int n, output int outcome);
    logic [63:0] nxt;
    n = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk); noise();
      imem_ack_i = (i == d.iw);
      if (i == d.iw) begin imem_err_i = d.ierr; imem_rdata_i = d.inst; end
      emit(S_IF, 1'b0); n++;
      if (i == d.iw) break;
    end
    if (d.iw >= TMO || d.ierr) begin absorb(S_FAULT); outcome = 2; return; end
    m_inst = d.inst;
    @(negedge clk); noise(); emit(S_ID, 1'b0); n++;
    @(negedge clk); noise();
    halt_i = d.halt; jump_flag_i = d.jump; jump_addr_i = d.jaddr; is_mem_i = d.is_mem;
    emit(S_EX, 1'b0); n++;
    if (d.halt) begin absorb(S_HALT); outcome = 1; return; end
    if (d.jump && d.jaddr[1:0] != 2'b00) begin absorb(S_FAULT); outcome = 2; return; end
    nxt = d.jump ? d.jaddr : m_pc + 64'd4;
    if (d.is_mem) begin
      for (int i = 0; i < TMO; i++) begin
        if (i == d.rst_ls) begin outcome = 3; return; end
        @(negedge clk); noise();
        dmem_ack_i = (i == d.dw);
        emit(S_LS, 1'b0); n++;
        if (i == d.dw) break;
      end
      if (d.dw >= TMO) begin absorb(S_FAULT); outcome = 2; return; end
    end
    @(negedge clk); noise(); rd_wr_en_i = d.rd_we;
    emit(S_WB, d.rd_we); n++;
    m_pc = nxt;
    outcome = 0;
  endtask

  function automatic ins_t mk();
    ins_t d;
    d.iw = 0; d.ierr = 0; d.is_mem = 0; d.dw = 0; d.halt = 0; d.jump = 0;
    d.jaddr = '0; d.rd_we = 1; d.inst = 32'h0010_0093; d.rst_ls = -1;
    return d;
  endfunction

  function automatic ins_t rnd();
    ins_t d;
    int r;
    d = mk();
    r = $urandom_range(0, 99);
    d.iw   = (r < 3) ? TMO : (r < 6) ? TMO - 1 : $urandom_range(0, 3);
    d.ierr = ($urandom_range(0, 29) == 0);
    d.is_mem = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 99);
    d.dw   = (r < 3) ? TMO : (r < 6) ? TMO - 1 : $urandom_range(0, 3);
    d.halt = ($urandom_range(0, 24) == 0);
    d.jump = ($urandom_range(0, 9) < 3);
    d.jaddr = {$urandom, $urandom} & ~64'h3;
    if ($urandom_range(0, 9) == 0) d.jaddr[1:0] = 2'($urandom_range(1, 3));
    d.rd_we = 1'($urandom_range(0, 1));
    d.inst  = $urandom;
    d.rst_ls = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
    return d;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    ins_t d;
    int   n, oc;

    do_reset(2, 1'b0);

    // addi: 4 cycles, pc advances by 4
    d = mk();
    run(d, n, oc);
    chk("addi_cycles", 64'(n), 64'd4);
    chk("addi_model_pc", m_pc, 64'h8000_0004);
    @(posedge clk); #1;
    chk("addi_pc", pc_o, 64'h8000_0004);

    // load with dmem ack delayed 3 cycles: 8 cycles, one retire
    do_reset(2, 1'b0);
    d = mk(); d.is_mem = 1; d.dw = 3; d.inst = 32'h0000_3083;
    run(d, n, oc);
    chk("load_cycles", 64'(n), 64'd8);
    chk("load_model_instret", m_ret, 64'd1);
`ifdef YSYX_22040237_PERF_CNT_EN
    @(posedge clk); #1;
    chk("load_instret", instret_o, 64'd1);
`endif

    // jal aligned, then misaligned
    d = mk(); d.jump = 1; d.jaddr = 64'h8000_0100; d.inst = 32'h0f80_00ef;
    run(d, n, oc);
    @(posedge clk); #1;
    chk("jal_pc", pc_o, 64'h8000_0100);
    d.jaddr = 64'h8000_0102;
    run(d, n, oc);
    chk("jal_mis_outcome", 64'(oc), 64'd2);
    #1;
    chk("jal_mis_fault", 64'(fault_o), 64'd1);
    chk("jal_mis_reqs", 64'({imem_req_o, dmem_req_o}), 64'd0);

    // fetch timeout vs ack on the last allowed cycle
    do_reset(2, 1'b0);
    d = mk(); d.iw = TMO;
    run(d, n, oc);
    chk("if_tmo_outcome", 64'(oc), 64'd2);
    #1;
    chk("if_tmo_fault", 64'(fault_o), 64'd1);
    do_reset(2, 1'b0);
    d = mk(); d.iw = TMO - 1;
    run(d, n, oc);
    chk("if_late_ack_cycles", 64'(n), 64'd19);

    // halt in EX
    do_reset(2, 1'b0);
    d = mk(); d.halt = 1; d.inst = 32'h0010_0073;
    run(d, n, oc);
    #1;
    chk("halt_flag", 64'(halted_o), 64'd1);
    chk("halt_rf", 64'(rf_wr_en_o), 64'd0);
    chk("halt_pc", pc_o, RST_PC);

    // pc wrap past 2^64
    do_reset(2, 1'b0);
    d = mk(); d.jump = 1; d.jaddr = 64'hFFFF_FFFF_FFFF_FFFC;
    run(d, n, oc);
    d = mk();
    run(d, n, oc);
    chk("wrap_model_pc", m_pc, 64'd0);
    @(posedge clk); #1;
    chk("wrap_pc", pc_o, 64'd0);

    // reset in the middle of a long LS wait
    d = mk(); d.is_mem = 1; d.dw = 10; d.rst_ls = 2;
    run(d, n, oc);
    do_reset(2, 1'b1);

    // randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      d = rnd();
      run(d, n, oc);
      if (oc != 0) do_reset(2, 1'b1);
    end

    @(negedge clk); @(negedge clk); #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
